// File: rtl/addsub_share_arb_pkg.sv
// Shared definitions for the add/sub sharing arbiter: op encodings, default sizes
// and the 32-bit carry-lookahead adder used by the shared datapath.
package addsub_share_arb_pkg;

  localparam int DEF_W    = 32;
  localparam int DEF_NREQ = 4;
  localparam int ADDER_W  = 32;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Returns {carry_out, sum}; 4-bit groups with group generate/propagate lookahead.
  function automatic logic [32:0] cla_add32(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic        cin);
    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;
    logic [7:0]  bg;
    logic [7:0]  bp;
    logic [8:0]  bc;
    g     = a & b;
    p     = a ^ b;
    bc[0] = cin;
    for (int k = 0; k < 8; k++) begin
      bg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      bp[k]   = &p[4*k +: 4];
      bc[k+1] = bg[k] | (bp[k] & bc[k]);
    end
    for (int k = 0; k < 8; k++) begin
      c[4*k]   = bc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & bc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & bc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & bc[k]);
    end
    c[32] = bc[8];
    return {c[32], p ^ c[31:0]};
  endfunction

endpackage

// File: rtl/addsub_share_arb_rr_arbiter.sv
// Round-robin arbiter: searches from ptr upward (mod N) for the first request,
// and moves ptr past the winner whenever a grant is actually issued.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 en,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr;
  logic [IW-1:0] cand;
  logic [IW-1:0] win;
  logic          found;

  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign gnt_idx = win;
  assign gnt     = (en && found) ? (N'(1) << win) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (en && |req) begin
      ptr <= (win == IW'(N-1)) ? '0 : win + 1'b1;
    end
  end

endmodule

// File: rtl/addsub_share_arb.sv
// Shares one 32-bit add/sub unit among NREQ requesters: round-robin accept,
// operand register (S1), adder, response register (S2) with back-pressure stall.
module addsub_share_arb
  import addsub_share_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int W    = DEF_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         op_sub,
  input  logic [NREQ*W-1:0]       op_a,
  input  logic [NREQ*W-1:0]       op_b,
  output logic [NREQ-1:0]         ack,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [W-1:0]            rsp_data,
  output logic                    rsp_cout,
  output logic                    rsp_ovf
);

  localparam int IW = $clog2(NREQ);

  logic          stall;
  logic          accept;
  logic [IW-1:0] gnt_idx;

  logic          s1_valid;
  logic [IW-1:0] s1_id;
  logic          s1_sub;
  logic [W-1:0]  s1_a;
  logic [W-1:0]  s1_b;

  logic [W-1:0]       b_in;
  logic [ADDER_W:0]   full;
  logic [W-1:0]       sum;
  logic               cout;
  logic               ovf;

  // A bubble in S2 never stalls, whatever rsp_ready says.
  assign stall  = rsp_valid & ~rsp_ready;
  assign accept = |ack;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .en      (~stall & ~rst),
    .gnt     (ack),
    .gnt_idx (gnt_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_id    <= '0;
      s1_sub   <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (!stall) begin
      s1_valid <= accept;
      if (accept) begin
        s1_id  <= gnt_idx;
        s1_sub <= op_sub[gnt_idx];
        s1_a   <= op_a[gnt_idx*W +: W];
        s1_b   <= op_b[gnt_idx*W +: W];
      end
    end
  end

  // Operands are zero-extended into the fixed-width adder; carry out of bit W-1 is full[W].
  assign b_in = (s1_sub == OP_ADD) ? s1_b : ~s1_b;
  assign full = cla_add32(ADDER_W'(s1_a), ADDER_W'(b_in), s1_sub == OP_SUB);
  assign sum  = full[W-1:0];
  assign cout = full[W];
  assign ovf  = (s1_a[W-1] ^ sum[W-1]) & (b_in[W-1] ^ sum[W-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_cout  <= 1'b0;
      rsp_ovf   <= 1'b0;
    end else if (!stall) begin
      rsp_valid <= s1_valid;
      rsp_id    <= s1_id;
      rsp_data  <= sum;
      rsp_cout  <= cout;
      rsp_ovf   <= ovf;
    end
  end

endmodule

// File: tb/tb_addsub_share_arb.sv
// Directed bench for addsub_share_arb: inputs change 1 time unit after the rising
// edge, outputs are checked at the falling edge.
module tb_addsub_share_arb;

  localparam int NREQ = 4;
  localparam int W    = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   op_sub;
  logic [NREQ*W-1:0] op_a;
  logic [NREQ*W-1:0] op_b;
  logic [NREQ-1:0]   ack;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [W-1:0]      rsp_data;
  logic              rsp_cout;
  logic              rsp_ovf;

  int n_cmp = 0;
  int n_err = 0;

  addsub_share_arb #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .op_sub    (op_sub),
    .op_a      (op_a),
    .op_b      (op_b),
    .ack       (ack),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_cout  (rsp_cout),
    .rsp_ovf   (rsp_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic sub, input logic [31:0] a, input logic [31:0] b);
    op_sub[i]       = sub;
    op_a[i*W +: W]  = a;
    op_b[i*W +: W]  = b;
  endtask

  task automatic chk_rsp(input string tag, input int id, input logic [31:0] data,
                         input logic cout, input logic ovf);
    chk({tag, "_vld"},  32'(rsp_valid), 1);
    chk({tag, "_id"},   32'(rsp_id),    32'(id));
    chk({tag, "_data"}, rsp_data,       data);
    chk({tag, "_cout"}, 32'(rsp_cout),  32'(cout));
    chk({tag, "_ovf"},  32'(rsp_ovf),   32'(ovf));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    req       = 4'b0001;
    op_sub    = '0;
    op_a      = '0;
    op_b      = '0;
    rsp_ready = 1'b1;
    set_op(0, 1'b0, 7, 5);

    // reset with a request pending: ack gated, outputs cleared
    tick(); #4;
    chk("rst_ack",  32'(ack), 0);
    chk("rst_vld",  32'(rsp_valid), 0);
    chk("rst_data", rsp_data, 0);

    // single add 7+5
    tick(); rst = 1'b0; #4;
    chk("add_ack", 32'(ack), 1);
    tick(); req = 4'b0000; #4;
    chk("add_ack_t1", 32'(ack), 0);
    chk("add_vld_t1", 32'(rsp_valid), 0);
    tick(); #4;
    chk_rsp("add", 0, 32'd12, 1'b0, 1'b0);

    // sub 5-7 on req0 (ptr=1, wraps to 0), then 0x7fffffff+1 on req1
    tick(); req = 4'b0001; set_op(0, 1'b1, 5, 7); #4;
    chk("sub_ack", 32'(ack), 1);
    tick(); req = 4'b0010; set_op(1, 1'b0, 32'h7FFF_FFFF, 1); #4;
    chk("ovf_ack", 32'(ack), 2);
    tick(); req = 4'b0000; #4;
    chk_rsp("sub", 0, 32'hFFFF_FFFE, 1'b0, 1'b0);
    tick(); #4;
    chk_rsp("ovf", 1, 32'h8000_0000, 1'b0, 1'b1);

    // reset ptr, then all four held for 8 cycles
    tick(); rst = 1'b1; req = '0; #4;
    for (int i = 0; i < NREQ; i++) set_op(i, 1'b0, 100 + i, i);
    for (int k = 0; k < 10; k++) begin
      tick(); rst = 1'b0; req = (k < 8) ? 4'b1111 : 4'b0000; #4;
      chk($sformatf("rr_ack%0d", k), 32'(ack), (k < 8) ? (1 << (k % 4)) : 0);
      if (k >= 2) begin
        chk($sformatf("rr_vld%0d", k),  32'(rsp_valid), 1);
        chk($sformatf("rr_id%0d", k),   32'(rsp_id), (k - 2) % 4);
        chk($sformatf("rr_data%0d", k), rsp_data, 100 + 2 * ((k - 2) % 4));
      end
    end

    // stall: S2 holds req0 result, req1 in S1, req2/req3 pending
    tick(); req = 4'b0001; rsp_ready = 1'b1;
    set_op(0, 1'b0, 10, 1);
    set_op(1, 1'b1, 20, 3);
    set_op(2, 1'b1, 0, 1);
    set_op(3, 1'b0, 32'hFFFF_FFFF, 1);
    #4;
    chk("st_ack0", 32'(ack), 1);
    tick(); req = 4'b0110; #4;
    chk("st_ack1", 32'(ack), 2);
    for (int k = 0; k < 3; k++) begin
      tick(); req = 4'b1100; rsp_ready = 1'b0; #4;
      chk($sformatf("st_hold_ack%0d", k), 32'(ack), 0);
      chk($sformatf("st_hold_id%0d", k),  32'(rsp_id), 0);
      chk($sformatf("st_hold_vld%0d", k), 32'(rsp_valid), 1);
      chk($sformatf("st_hold_dat%0d", k), rsp_data, 11);
    end
    tick(); rsp_ready = 1'b1; #4;
    chk("st_rel_ack", 32'(ack), 4);
    chk_rsp("st_r0", 0, 32'd11, 1'b0, 1'b0);
    tick(); req = 4'b1000; #4;
    chk("st_ack3", 32'(ack), 8);
    chk_rsp("st_r1", 1, 32'd17, 1'b1, 1'b0);
    tick(); req = 4'b0000; #4;
    chk_rsp("st_r2", 2, 32'hFFFF_FFFF, 1'b0, 1'b0);
    tick(); #4;
    chk_rsp("st_r3", 3, 32'd0, 1'b1, 1'b0);
    tick(); #4;
    chk("st_drain", 32'(rsp_valid), 0);

    // reset one cycle after an ack drops that op and returns ptr to 0
    tick(); req = 4'b0001; #4;
    chk("rf_ack", 32'(ack), 1);
    tick(); rst = 1'b1; req = 4'b1111; #4;
    chk("rf_ack_rst", 32'(ack), 0);
    tick(); rst = 1'b0; #4;
    chk("rf_vld_t2", 32'(rsp_valid), 0);
    chk("rf_ack_ptr0", 32'(ack), 1);
    tick(); req = 4'b0000; #4;
    chk("rf_vld_t3", 32'(rsp_valid), 0);
    tick(); #4;
    chk("rf_vld_t4", 32'(rsp_valid), 1);
    chk("rf_id_t4",  32'(rsp_id), 0);
    tick(); #4;

    // requester 2 alone with idle gaps; rsp_ready low during bubbles
    for (int k = 0; k < 9; k++) begin
      tick();
      req = (k % 3 == 0 && k < 7) ? 4'b0100 : 4'b0000;
      if (req[2]) set_op(2, 1'b0, 1000 + k, k);
      rsp_ready = (k % 3 == 2);
      #4;
      chk($sformatf("bub_ack%0d", k), 32'(ack), (k % 3 == 0 && k < 7) ? 4 : 0);
      chk($sformatf("bub_vld%0d", k), 32'(rsp_valid), (k % 3 == 2) ? 1 : 0);
      if (k % 3 == 2) begin
        chk($sformatf("bub_id%0d", k),   32'(rsp_id), 2);
        chk($sformatf("bub_data%0d", k), rsp_data, 1000 + 2 * (k - 2));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
